// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared constants, slot type and sizing helpers for the prefetch queue.
// The ring and the top both derive their pointer widths from these helpers.
package fetch_prefetch_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fetch_slot_t;

    function automatic int ring_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-side bundle: decode control (stall/redirect), instruction memory
// request/response, and the instruction presented to the IF/ID register.
interface fetch_prefetch_queue_if;
    import fetch_prefetch_queue_pkg::*;

    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] inst_pc_plus4;

    modport master (
        input  stall, redirect, redirect_pc,
        input  imem_ready, imem_rvalid, imem_rdata,
        output imem_req, imem_addr,
        output inst_valid, inst, inst_pc, inst_pc_plus4
    );

    modport slave (
        output stall, redirect, redirect_pc,
        output imem_ready, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr,
        input  inst_valid, inst, inst_pc, inst_pc_plus4
    );

endinterface

// File: rtl/fetch_prefetch_queue_entry_ring.sv
// DEPTH-entry storage of {pc, word, filled}; slots are addressed by the
// caller's pointers and the head slot is read combinationally.
module fetch_entry_ring
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = ring_ptr_width(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clear,
    input  logic            i_reserve,
    input  logic [PW-1:0]   i_reserve_idx,
    input  logic [XLEN-1:0] i_reserve_pc,
    input  logic            i_fill,
    input  logic [PW-1:0]   i_fill_idx,
    input  logic [XLEN-1:0] i_fill_word,
    input  logic            i_pop,
    input  logic [PW-1:0]   i_head_idx,
    output logic [XLEN-1:0] o_head_pc,
    output logic [XLEN-1:0] o_head_word,
    output logic            o_head_filled
);

    fetch_slot_t      w_slot [DEPTH];
    logic [DEPTH-1:0] w_filled;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            fetch_slot_t r_slot;
            logic        r_filled;
            logic        w_hit_reserve;
            logic        w_hit_fill;
            logic        w_hit_pop;

            assign w_hit_reserve = i_reserve && (i_reserve_idx == PW'(gi));
            assign w_hit_fill    = i_fill    && (i_fill_idx    == PW'(gi));
            assign w_hit_pop     = i_pop     && (i_head_idx    == PW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_slot.pc   <= '0;
                    r_slot.word <= NOP_INSTR;
                    r_filled    <= 1'b0;
                end else begin
                    if (w_hit_reserve) begin
                        r_slot.pc <= i_reserve_pc;
                    end
                    if (w_hit_fill) begin
                        r_slot.word <= i_fill_word;
                    end
                    // A flush beats everything; fill and pop never target the same slot.
                    if (i_clear) begin
                        r_filled <= 1'b0;
                    end else if (w_hit_fill) begin
                        r_filled <= 1'b1;
                    end else if (w_hit_pop) begin
                        r_filled <= 1'b0;
                    end
                end
            end

            assign w_slot[gi]   = r_slot;
            assign w_filled[gi] = r_filled;
        end
    endgenerate

    assign o_head_pc     = w_slot[i_head_idx].pc;
    assign o_head_word   = w_slot[i_head_idx].word;
    assign o_head_filled = w_filled[i_head_idx];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Prefetching instruction-fetch front end: sequential requests into an in-order
// ring, one instruction per cycle to decode, with redirect flush and stall hold.
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fetch_prefetch_queue_if.master  bus
);

    localparam int PW = ring_ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam int SW = CW + 1;
    localparam logic [PW:0]   PTR_ONE = (PW + 1)'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [XLEN-1:0] r_fetch_pc;
    logic [PW:0]     r_alloc;
    logic [PW:0]     r_fill;
    logic [PW:0]     r_head;
    logic [CW-1:0]   r_discard;

    logic [PW:0]     w_occ;
    logic [PW:0]     w_ring_inflight;
    logic [SW-1:0]   w_budget;
    logic            w_req;
    logic            w_xfer;
    logic            w_fill;
    logic            w_drop;
    logic            w_pop;
    logic [XLEN-1:0] w_head_pc;
    logic [XLEN-1:0] w_head_word;
    logic            w_head_filled;
    logic [1:0]      w_unused_pc_lsb;

    assign w_unused_pc_lsb = bus.redirect_pc[1:0];

    // Pointers carry one extra wrap bit so a full ring is distinguishable from empty.
    always_comb begin
        w_occ           = r_alloc - r_head;
        w_ring_inflight = r_alloc - r_fill;
        w_budget        = SW'(w_occ) + SW'(r_discard);
        w_req           = rst_n && !bus.redirect && (w_budget < SW'(DEPTH));
        w_xfer          = w_req && bus.imem_ready;
        w_fill          = bus.imem_rvalid && !bus.redirect && (r_discard == '0);
        w_drop          = bus.imem_rvalid && (r_discard != '0);
        w_pop           = w_head_filled && !bus.stall && !bus.redirect;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_alloc    <= '0;
            r_fill     <= '0;
            r_head     <= '0;
            r_discard  <= '0;
        end else if (bus.redirect) begin
            // Every outstanding request, including one answering right now, is now stale.
            r_fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            r_fill     <= r_alloc;
            r_head     <= r_alloc;
            r_discard  <= r_discard + CW'(w_ring_inflight) - CW'(bus.imem_rvalid);
        end else begin
            if (w_xfer) begin
                r_alloc    <= r_alloc + PTR_ONE;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_fill) begin
                r_fill <= r_fill + PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_ONE;
            end
            if (w_drop) begin
                r_discard <= r_discard - CNT_ONE;
            end
        end
    end

    fetch_entry_ring #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_ring (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (bus.redirect),
        .i_reserve     (w_xfer),
        .i_reserve_idx (r_alloc[PW-1:0]),
        .i_reserve_pc  (r_fetch_pc),
        .i_fill        (w_fill),
        .i_fill_idx    (r_fill[PW-1:0]),
        .i_fill_word   (bus.imem_rdata),
        .i_pop         (w_pop),
        .i_head_idx    (r_head[PW-1:0]),
        .o_head_pc     (w_head_pc),
        .o_head_word   (w_head_word),
        .o_head_filled (w_head_filled)
    );

    assign bus.imem_req      = w_req;
    assign bus.imem_addr     = r_fetch_pc;
    assign bus.inst_valid    = w_head_filled;
    assign bus.inst          = w_head_filled ? w_head_word : NOP_INSTR;
    assign bus.inst_pc       = w_head_pc;
    assign bus.inst_pc_plus4 = w_head_pc + 32'd4;

endmodule
